// File: rtl/uart_oversampled_rx.sv
// uart_oversampled_rx
// UART receiver for 8N1-style frames (start 0, DATA_WIDTH bits LSB first, one stop 1).
// The line is sampled at 16x the bit rate. Each bit is a majority vote of samples 7, 8 and 9.
// A received byte goes into a one-entry holding register.
// Handshake: a byte is consumed at a rising clk edge where rx_valid and rx_accept are both 1.
// byteFromRx stays stable while rx_valid is 1. rx_accept is ignored while rx_valid is 0.
// framing_error and overrun are one-cycle pulses.
// o_dbg_state exposes the FSM state encoding for checkers.

module uart_oversampled_rx #(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_RATE  = 19200,
   parameter int CLK_FREQ   = 50_000_000,
   parameter int OVERSAMPLE = 16
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] byteFromRx,
   output logic                  rx_valid,
   input  logic                  rx_accept,
   output logic                  rx_busy,
   output logic                  framing_error,
   output logic                  overrun,
   output logic [2:0]            o_dbg_state
);

   // Clocks per sample tick, truncated (162 at 50 MHz / 19200 baud)
   localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int S_W   = $clog2(OVERSAMPLE);
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_STOP      = 3'd3;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

   logic                  r_sync1;
   logic                  r_sync2;
   logic                  r_rx_prev;
   logic [2:0]            r_state;
   logic [CNT_W-1:0]      r_tick_cnt;
   logic [S_W-1:0]        r_s;
   logic [IDX_W-1:0]      r_bit_idx;
   logic                  r_samp7;
   logic                  r_samp8;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_deliver;
   logic                  r_framing_error;
   logic [DATA_WIDTH-1:0] r_byte;
   logic                  r_valid;
   logic                  r_overrun;

   logic                  w_rx_s;
   logic                  w_tick;
   logic [S_W-1:0]        w_s_next;
   logic                  w_fall;
   logic                  w_decide;
   logic                  w_wrap;
   logic                  w_maj;

   assign w_rx_s   = r_sync2;
   assign w_tick   = (r_state != ST_IDLE) && (r_tick_cnt == CNT_W'(DIV - 1));
   assign w_s_next = r_s + 1'b1;
   assign w_fall   = r_rx_prev & ~w_rx_s;
   // Sample points are named by the index s reaches on that tick. Index 9 lands one tick past mid-bit.
   assign w_decide = w_tick && (w_s_next == S_W'(9));
   assign w_wrap   = w_tick && (r_s == S_W'(OVERSAMPLE - 1));
   // Third vote is the live synchronized line on the deciding tick
   assign w_maj    = (r_samp7 & r_samp8) | (r_samp7 & w_rx_s) | (r_samp8 & w_rx_s);

   // Two-flop synchronizer plus one delayed copy for falling-edge detection; idles high
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync1   <= rx;
         r_sync2   <= r_sync1;
         r_rx_prev <= r_sync2;
      end
   end

   // Receive FSM with tick divider, sample index, voting samples and shift register
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state         <= ST_IDLE;
         r_tick_cnt      <= '0;
         r_s             <= '0;
         r_bit_idx       <= '0;
         r_samp7         <= 1'b0;
         r_samp8         <= 1'b0;
         r_shift         <= '0;
         r_deliver       <= 1'b0;
         r_framing_error <= 1'b0;
      end else begin
         r_deliver       <= 1'b0;
         r_framing_error <= 1'b0;

         // Divider is held at zero in IDLE, so ticks line up with the start edge
         if (r_state == ST_IDLE || w_tick) begin
            r_tick_cnt <= '0;
         end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
         end

         if (w_tick) begin
            r_s <= w_s_next;
            if (w_s_next == S_W'(7)) r_samp7 <= w_rx_s;
            if (w_s_next == S_W'(8)) r_samp8 <= w_rx_s;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_fall) begin
                  r_state <= ST_START;
                  r_s     <= '0;
               end
            end
            ST_START: begin
               if (w_decide && w_maj) begin
                  // Glitch on an idle line: not a real start bit
                  r_state <= ST_IDLE;
               end else if (w_wrap) begin
                  r_state   <= ST_DATA;
                  r_bit_idx <= '0;
               end
            end
            ST_DATA: begin
               if (w_decide) r_shift[r_bit_idx] <= w_maj;
               if (w_wrap) begin
                  if (r_bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                     r_state <= ST_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end
            end
            ST_STOP: begin
               // Leave right at mid-stop so a back-to-back start edge is seen
               if (w_decide) begin
                  if (w_maj) begin
                     r_deliver <= 1'b1;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_framing_error <= 1'b1;
                     r_state         <= ST_WAIT_HIGH;
                  end
               end
            end
            ST_WAIT_HIGH: begin
               // A held-low line (break) parks here until it returns high
               if (w_rx_s) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Holding register: a delivery takes priority, a full register without accept drops the new byte
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_byte    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (r_deliver) begin
            if (!r_valid || rx_accept) begin
               r_byte  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && rx_accept) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign byteFromRx    = r_byte;
   assign rx_valid      = r_valid;
   assign rx_busy       = (r_state != ST_IDLE);
   assign framing_error = r_framing_error;
   assign overrun       = r_overrun;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_uart_oversampled_rx.sv
// Directed testbench for uart_oversampled_rx.
// The clock frequency is scaled so that one sample tick is 10 clocks and one bit is 160 clocks.

module tb_uart_oversampled_rx;

  localparam int CLK_FREQ = 3_072_000;  // DIV = 3072000 / (19200 * 16) = 10
  localparam int DIV      = 10;
  localparam int BIT      = 16 * DIV;
  localparam int G_PRE    = 76;         // glitch covers the s=8 sample only (s=7 ~70, s=9 ~90)
  localparam int G_LEN    = 10;
  localparam logic [2:0] IDLE_ST = 3'd0;
  localparam logic [2:0] DATA_ST = 3'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] byte_out;
  logic       rx_valid;
  logic       rx_accept;
  logic       rx_busy;
  logic       framing_error;
  logic       overrun;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  uart_oversampled_rx #(
    .DATA_WIDTH(8),
    .BAUD_RATE (19200),
    .CLK_FREQ  (CLK_FREQ),
    .OVERSAMPLE(16)
  ) dut (
    .clk          (clk),
    .rstN         (rst_n),
    .rx           (rx),
    .byteFromRx   (byte_out),
    .rx_valid     (rx_valid),
    .rx_accept    (rx_accept),
    .rx_busy      (rx_busy),
    .framing_error(framing_error),
    .overrun      (overrun),
    .o_dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // pulse counters: count high cycles so a wide pulse shows as >1
  always @(posedge clk) begin
    #1;
    if (framing_error === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // driver tasks (all start and end 1 time unit after a rising edge)
  task automatic send_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_head(input logic [7:0] d, input int glitch_bit);
    send_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        send_bit(d[i], G_PRE);
        send_bit(~d[i], G_LEN);
        send_bit(d[i], BIT - G_PRE - G_LEN);
      end else begin
        send_bit(d[i], BIT);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_head(d, -1);
    send_bit(1'b1, BIT);
  endtask

  task automatic accept_one();
    rx_accept = 1'b1;
    @(posedge clk);
    #1;
    rx_accept = 1'b0;
  endtask

  initial begin
    bit timed_out;
    rst_n     = 1'b0;
    rx        = 1'b1;
    rx_accept = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte", byte_out, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_fe", framing_error, 1'b0);
    check("rst_ov", overrun, 1'b0);
    check("rst_state", dbg_state, IDLE_ST);
    rst_n = 1'b1;
    send_bit(1'b1, 20);

    // 1: nominal frame 0xA5, busy falls near mid-stop
    send_head(8'hA5, -1);
    send_bit(1'b1, 60);
    check("t1_busy_before_mid_stop", rx_busy, 1'b1);
    send_bit(1'b1, 50);
    check("t1_busy_after_mid_stop", rx_busy, 1'b0);
    check("t1_valid", rx_valid, 1'b1);
    check("t1_byte", byte_out, 8'hA5);
    send_bit(1'b1, BIT - 110);
    check("t1_fe", fe_cnt, 0);
    accept_one();
    check("t1_consumed", rx_valid, 1'b0);
    check("t1_byte_hold", byte_out, 8'hA5);

    // 2: 0x3C with bit 2 glitched around its middle sample
    send_head(8'h3C, 2);
    send_bit(1'b1, BIT);
    check("t2_valid", rx_valid, 1'b1);
    check("t2_byte", byte_out, 8'h3C);
    check("t2_fe", fe_cnt, 0);
    accept_one();

    // 3: false start, then 0x81
    send_bit(1'b0, 4 * DIV);
    send_bit(1'b1, 3 * BIT);
    check("t3_valid", rx_valid, 1'b0);
    check("t3_busy", rx_busy, 1'b0);
    check("t3_state", dbg_state, IDLE_ST);
    check("t3_fe", fe_cnt, 0);
    check("t3_ov", ov_cnt, 0);
    send_frame(8'h81);
    check("t3_valid2", rx_valid, 1'b1);
    check("t3_byte2", byte_out, 8'h81);
    accept_one();

    // 4: bad stop bit then break
    send_head(8'h5E, -1);
    send_bit(1'b0, BIT);
    send_bit(1'b0, 3 * BIT);
    check("t4_fe_pulse", fe_cnt, 1);
    check("t4_valid", rx_valid, 1'b0);
    check("t4_busy_low_line", rx_busy, 1'b1);
    send_bit(1'b1, 5);
    check("t4_busy_released", rx_busy, 1'b0);
    send_bit(1'b1, 2 * BIT);
    check("t4_no_byte", rx_valid, 1'b0);
    check("t4_fe_once", fe_cnt, 1);

    // 5a: back-to-back 0x11, 0x22 without accept -> overrun
    ov_cnt = 0;
    send_frame(8'h11);
    send_frame(8'h22);
    check("t5a_byte", byte_out, 8'h11);
    check("t5a_valid", rx_valid, 1'b1);
    check("t5a_ov_pulse", ov_cnt, 1);
    accept_one();
    check("t5a_consumed", rx_valid, 1'b0);
    check("t5a_byte_hold", byte_out, 8'h11);

    // 5b: accept exactly in 0x22's delivery cycle
    send_frame(8'h11);
    ov_cnt = 0;
    timed_out = 1'b0;
    fork
      send_frame(8'h22);
      begin
        int n;
        n = 0;
        while (rx_busy !== 1'b1 && n < 100) begin
          @(posedge clk); #1; n++;
        end
        if (n >= 100) timed_out = 1'b1;
        n = 0;
        while (rx_busy !== 1'b0 && n < 12 * BIT) begin
          @(posedge clk); #1; n++;
        end
        if (n >= 12 * BIT) timed_out = 1'b1;
        accept_one();
      end
    join
    check("t5b_timeout", timed_out, 1'b0);
    check("t5b_byte", byte_out, 8'h22);
    check("t5b_valid", rx_valid, 1'b1);
    check("t5b_no_ov", ov_cnt, 0);

    // 6: reset in the middle of 0xFF's data bits
    send_bit(1'b0, BIT);
    send_bit(1'b1, 3 * BIT + 50);
    check("t6_in_data", dbg_state, DATA_ST);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_rst_byte", byte_out, 8'h00);
    check("t6_rst_valid", rx_valid, 1'b0);
    check("t6_rst_busy", rx_busy, 1'b0);
    check("t6_rst_state", dbg_state, IDLE_ST);
    rst_n = 1'b1;
    send_bit(1'b1, 2 * BIT);
    fe_cnt = 0;
    ov_cnt = 0;
    send_frame(8'h5A);
    check("t6_byte", byte_out, 8'h5A);
    check("t6_valid", rx_valid, 1'b1);
    check("t6_fe", fe_cnt, 0);
    check("t6_ov", ov_cnt, 0);

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_oversampled_rx.md
Name: uart_oversampled_rx

Overview:
Synthesizable UART receiver that recovers bytes from the serial line driven by a remote transmitter, the opposite end of the line the system's transmitter drives.
- Frame format: 8N1 by default (start 0, DATA_WIDTH bits LSB first, one stop 1).
- Samples the line at 16x baud with majority voting.
- Presents bytes through a one-entry valid/accept holding register.
- Flags framing and overrun errors.

Parameters:
DATA_WIDTH, 8, data bits per frame
BAUD_RATE, 19200, line rate in bit/s
CLK_FREQ, 50_000_000, clk frequency in Hz
OVERSAMPLE, 16, sample ticks per bit (fixed 16; other values unsupported)

Ports:
clk  input  1  system clock, rising edge
rstN  input  1  asynchronous active-low reset
rx  input  1  serial line, asynchronous to clk, idle high
byteFromRx  output  DATA_WIDTH  received byte, stable while rx_valid=1
rx_valid  output  1  holding register holds an unconsumed byte
rx_accept  input  1  consumer takes byte when rx_valid & rx_accept at posedge
rx_busy  output  1  high in every state except IDLE
framing_error  output  1  one-cycle pulse: stop bit sampled 0
overrun  output  1  one-cycle pulse: completed byte dropped because holding register was full

Behaviour:
- Reset (rstN=0, async):
  - State IDLE; all counters 0.
  - Synchronizer flops set to 1.
  - byteFromRx=0; rx_valid, rx_busy, framing_error and overrun all 0.
  - Applies mid-frame; the partial byte is discarded.
- Synchronizer: rx passes through 2 flops (rx_s). All decisions use rx_s, giving 2 cycles of input latency.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*16) by integer truncation; default 162.
  - Counter runs 0..DIV-1 and pulses tick when it equals DIV-1.
  - Cleared on IDLE->START so ticks align to the start edge.
  - Sample index s counts 0..15 on ticks and wraps into the next bit.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: rx_s falling (prev 1, now 0) -> START; s=0.
- Bit evaluation (all states): capture rx_s on ticks where s is 7, 8 and 9; bit value = majority of the 3 samples, decided on the s=9 tick.
- START:
  - Majority 1 -> false start; go to IDLE, no flags.
  - Majority 0 -> at s=15 wrap go to DATA, bit index 0.
- DATA:
  - Majority value shifts into the shift register LSB-first, at bit position = bit index.
  - After bit DATA_WIDTH-1 wraps -> STOP.
- STOP, on the s=9 decision:
  - Majority 1 -> deliver byte and go directly to IDLE (no wait for end of stop bit), so back-to-back frames resynchronize.
  - Majority 0 -> framing_error pulses 1 cycle, byte discarded; go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then IDLE. A line held low (break) never produces bytes.
- Delivery (cycle after the STOP s=9 tick):
  - rx_valid=0 -> load byteFromRx, rx_valid=1.
  - rx_valid=1 and rx_accept=1 in the delivery cycle -> old byte consumed, new byte loaded, rx_valid stays 1, no overrun.
  - rx_valid=1 and rx_accept=0 -> overrun pulses 1 cycle; new byte dropped, old byte and rx_valid unchanged.
- Consumption: rx_valid & rx_accept at posedge with no delivery -> rx_valid=0 next cycle; byteFromRx holds its last value.
- rx_accept while rx_valid=0 is ignored.
- Overall latency: rx_valid rises at most 2 + DIV + 1 cycles after the mid-stop-bit point on the raw rx line.

Test Plan:
1. Frame 0xA5 at nominal 19200 bit period (2592 clk per bit) -> rx_valid=1 with byteFromRx=0xA5; framing_error=0; rx_busy falls at mid-stop-bit.
2. Frame 0x3C with one data bit's raw line inverted for 200 clk around s=8 -> byteFromRx=0x3C, since majority voting rejects the glitch.
3. rx low for 4*162 clk then high, no frame -> false start: no rx_valid, no flags, back in IDLE; a following 0x81 frame is received correctly.
4. Frame 0x5E with stop bit 0, then line held low for 3 bit times -> framing_error one pulse; rx_valid=0; rx_busy high until rx returns high; no second byte.
5. Frames 0x11 and 0x22 back-to-back, rx_accept=0 throughout -> byteFromRx=0x11, overrun one pulse. Then rx_accept=1 for one cycle -> rx_valid=0. Repeat with rx_accept=1 exactly in 0x22's delivery cycle -> byteFromRx=0x22, rx_valid stays 1, overrun=0.
6. rstN low for 3 cycles mid-DATA of frame 0xFF -> all outputs 0, IDLE. Next full frame 0x5A -> byteFromRx=0x5A, no error flags.
